// File: rtl/conv_pkg.sv
// Shared types and size helpers for the 3x3 convolution datapath.
// Used by the pad inserter, line buffers and window stages.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TOP,
    LEFT,
    BODY,
    RIGHT,
    BOTTOM
  } pad_state_t;

  // Padded dimension: one border pixel on each side.
  function automatic int pad_dim(input int n);
    return n + 2;
  endfunction

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_pad_inserter.sv
// Wraps an unpadded pixel stream in a one-pixel PAD_VAL border.
// Output is valid-only and registered; input uses valid/ready.
module conv_pad_inserter
  import conv_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               IMG_W   = 480,
  parameter int               IMG_H   = 270,
  parameter logic [WIDTH-1:0] PAD_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_sof,
  output logic             dout_eol
);

  localparam int PAD_W = pad_dim(IMG_W);
  localparam int CW    = cnt_w(PAD_W);
  localparam int RW    = cnt_w(IMG_H);

  localparam logic [CW-1:0] COL_PAD_LAST  = CW'(PAD_W - 1);
  localparam logic [CW-1:0] COL_BODY_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);

  pad_state_t state_q, state_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  logic             emit;
  logic [WIDTH-1:0] pix;
  logic             sof;
  logic             eol;
  logic             row_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        col_q <= '0;
      else if (emit)
        col_q <= col_q + 1'b1;
      if (state_q == IDLE)
        row_q <= '0;
      else if (row_inc)
        row_q <= row_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    din_ready = 1'b0;
    emit      = 1'b0;
    pix       = PAD_VAL;
    sof       = 1'b0;
    eol       = 1'b0;
    row_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din_valid)
          state_d = TOP;
      end
      TOP: begin
        emit = 1'b1;
        sof  = (col_q == '0);
        if (col_q == COL_PAD_LAST) begin
          eol     = 1'b1;
          state_d = LEFT;
        end
      end
      LEFT: begin
        emit    = 1'b1;
        state_d = BODY;
      end
      BODY: begin
        din_ready = 1'b1;
        if (din_valid) begin
          emit = 1'b1;
          pix  = din;
          if (col_q == COL_BODY_LAST)
            state_d = RIGHT;
        end
      end
      RIGHT: begin
        emit = 1'b1;
        eol  = 1'b1;
        if (row_q == ROW_LAST) begin
          state_d = BOTTOM;
        end else begin
          row_inc = 1'b1;
          state_d = LEFT;
        end
      end
      BOTTOM: begin
        emit = 1'b1;
        if (col_q == COL_PAD_LAST) begin
          eol     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // dout holds its last value between beats; only dout_valid qualifies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eol   <= 1'b0;
    end else begin
      dout_valid <= emit;
      dout_sof   <= emit & sof;
      dout_eol   <= emit & eol;
      if (emit)
        dout <= pix;
    end
  end

endmodule

// File: tb/tb_conv_pad_inserter.sv
// Scoreboard bench for conv_pad_inserter: a 4x2 frame instance and
// a 1x1 instance with an all-ones border.
module tb_conv_pad_inserter;

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_sof;
  logic       dout_eol;

  logic       b_rst;
  logic [7:0] b_din;
  logic       b_din_valid;
  logic       b_din_ready;
  logic [7:0] b_dout;
  logic       b_dout_valid;
  logic       b_dout_sof;
  logic       b_dout_eol;

  conv_pad_inserter #(
    .WIDTH(8), .IMG_W(4), .IMG_H(2), .PAD_VAL(8'h00)
  ) dut_a (
    .clk(clk), .rst(rst),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid),
    .dout_sof(dout_sof), .dout_eol(dout_eol)
  );

  conv_pad_inserter #(
    .WIDTH(8), .IMG_W(1), .IMG_H(1), .PAD_VAL(8'hFF)
  ) dut_b (
    .clk(clk), .rst(b_rst),
    .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .dout(b_dout), .dout_valid(b_dout_valid),
    .dout_sof(b_dout_sof), .dout_eol(b_dout_eol)
  );

  int exp_a [24] = '{
    0, 0, 0, 0, 0, 0,
    0, 1, 2, 3, 4, 0,
    0, 5, 6, 7, 8, 0,
    0, 0, 0, 0, 0, 0
  };
  int exp_b [9] = '{255, 255, 255, 255, 90, 255, 255, 255, 255};

  beat_t qa[$];
  beat_t qb[$];
  int    beat_cyc[$];
  int    cyc = 0;
  int    rdy_cnt = 0;
  bit    chk_a = 1'b1;
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst && din_ready) rdy_cnt <= rdy_cnt + 1;

  always @(negedge clk) begin : mon_a
    beat_t e;
    if (!rst && chk_a && dout_valid) begin
      if (qa.size() == 0) begin
        check("a_extra_beat", 32'd1, 32'd0);
      end else begin
        e = qa.pop_front();
        check("a_pix", 32'(dout), 32'(e.pix));
        check("a_sof", 32'(dout_sof), 32'(e.sof));
        check("a_eol", 32'(dout_eol), 32'(e.eol));
        beat_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    beat_t e;
    if (!b_rst && b_dout_valid) begin
      if (qb.size() == 0) begin
        check("b_extra_beat", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        check("b_pix", 32'(b_dout), 32'(e.pix));
        check("b_sof", 32'(b_dout_sof), 32'(e.sof));
        check("b_eol", 32'(b_dout_eol), 32'(e.eol));
      end
    end
  end

  task automatic push_a();
    beat_t b;
    for (int i = 0; i < 24; i++) begin
      b.pix = 8'(exp_a[i]);
      b.sof = (i == 0);
      b.eol = (i % 6 == 5);
      qa.push_back(b);
    end
  endtask

  task automatic push_b();
    beat_t b;
    for (int i = 0; i < 9; i++) begin
      b.pix = 8'(exp_b[i]);
      b.sof = (i == 0);
      b.eol = (i % 3 == 2);
      qb.push_back(b);
    end
  endtask

  // Offers pixels first..first+n-1; leaves din_valid high at the end.
  task automatic drive(input int first, input int n,
                       input int gap_after, input int gap_len);
    for (int k = 0; k < n; k++) begin
      int  wait_c;
      bit  acc;
      wait_c    = 0;
      acc       = 1'b0;
      din       = 8'(first + k);
      din_valid = 1'b1;
      while (!acc) begin
        @(negedge clk);
        acc = din_ready;
        @(posedge clk);
        #1;
        wait_c++;
        if (wait_c > 100) begin
          check("a_accept_timeout", 32'd0, 32'd1);
          return;
        end
      end
      if (k + 1 == gap_after) begin
        din_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          check("a_ready_in_gap", 32'(din_ready), 32'd1);
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain_a(input string name);
    int t;
    t = 0;
    while (qa.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(name, 32'(qa.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int t;
    rst = 1'b1;       b_rst = 1'b1;
    din = '0;         din_valid = 1'b0;
    b_din = '0;       b_din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_sof", 32'(dout_sof), 32'd0);
    check("rst_eol", 32'(dout_eol), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd0);
    rst = 1'b0;
    b_rst = 1'b0;
    @(posedge clk);
    #1;

    // Continuous frame; din_valid stays high through every border.
    push_a();
    beat_cyc.delete();
    rdy_cnt = 0;
    c0 = cyc;
    drive(1, 8, 0, 0);
    din_valid = 1'b0;
    drain_a("cont_drain");
    check("cont_first_latency", 32'(beat_cyc[0] - c0), 32'd2);
    check("cont_contiguous", 32'(beat_cyc[23] - beat_cyc[0]), 32'd23);
    check("cont_ready_cycles", 32'(rdy_cnt), 32'd8);

    // Three-cycle upstream gap after pixel 2.
    push_a();
    beat_cyc.delete();
    drive(1, 8, 2, 3);
    din_valid = 1'b0;
    drain_a("gap_drain");
    check("gap_before", 32'(beat_cyc[8] - beat_cyc[7]), 32'd1);
    check("gap_len", 32'(beat_cyc[9] - beat_cyc[8]), 32'd4);

    // Two frames back to back with din_valid held high.
    push_a();
    push_a();
    beat_cyc.delete();
    drive(1, 8, 0, 0);
    drive(1, 8, 0, 0);
    din_valid = 1'b0;
    drain_a("b2b_drain");
    check("b2b_beats", 32'(beat_cyc.size()), 32'd48);
    check("b2b_idle_gap", 32'(beat_cyc[24] - beat_cyc[23]), 32'd2);

    // Reset mid-frame, then a clean frame.
    chk_a = 1'b0;
    drive(1, 6, 0, 0);
    din_valid = 1'b0;
    check("pre_rst_valid", 32'(dout_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_eol", 32'(dout_eol), 32'd0);
    check("mid_rst_ready", 32'(din_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete();
    beat_cyc.delete();
    chk_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(dout_valid), 32'd0);
    push_a();
    drive(1, 8, 0, 0);
    din_valid = 1'b0;
    drain_a("post_rst_drain");
    check("post_rst_beats", 32'(beat_cyc.size()), 32'd24);

    // 1x1 image, all-ones border.
    push_b();
    b_din = 8'h5A;
    b_din_valid = 1'b1;
    t = 0;
    while (t < 100) begin
      @(negedge clk);
      if (b_din_ready) break;
      t++;
    end
    check("b_accept", 32'(b_din_ready), 32'd1);
    @(posedge clk);
    #1;
    b_din_valid = 1'b0;
    t = 0;
    while (qb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("b_drain", 32'(qb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
